// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs data-memory accesses over a req/ready handshake,
// resolves branch/jump redirects and registers the retiring instruction into MEM/WB.
module mem_access_stage #(
  parameter int TIMEOUT  = 255,
  parameter int TO_WIDTH = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        in_Valid,
  input  logic [31:0] in_ALU_result,
  input  logic [31:0] in_Read_data,
  input  logic [31:0] in_Next_PC,
  input  logic [31:0] in_Branch_addr,
  input  logic [31:0] in_Jump_addr,
  input  logic [4:0]  in_Reg_Write_addr,
  input  logic        in_MemWrite,
  input  logic        in_MemRead,
  input  logic        in_MemToReg,
  input  logic        in_PCSrc,
  input  logic        in_JToPC,
  input  logic        in_RegWrite,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        out_Valid,
  output logic [31:0] out_Write_data,
  output logic [31:0] out_Next_PC,
  output logic [4:0]  out_Reg_Write_addr,
  output logic        out_RegWrite,
  output logic        err_misalign,
  output logic        err_timeout
);

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] next_pc;
    logic [31:0] branch;
    logic [31:0] jump;
    logic [4:0]  rd;
    logic        we;
    logic        mem_to_reg;
    logic        pc_src;
    logic        j_to_pc;
    logic        reg_write;
  } instr_t;

  state_t              state, state_nxt;
  logic [TO_WIDTH-1:0] cnt;
  instr_t              in_instr, cap, cur;

  logic memop, misaligned, issue, misalign_retire, timeout_hit;
  logic retire, wr_en, redirect;
  logic [31:0] write_data;

  always_comb begin
    in_instr = '{alu: in_ALU_result, wdata: in_Read_data, next_pc: in_Next_PC,
                 branch: in_Branch_addr, jump: in_Jump_addr, rd: in_Reg_Write_addr,
                 we: in_MemWrite, mem_to_reg: in_MemToReg, pc_src: in_PCSrc,
                 j_to_pc: in_JToPC, reg_write: in_RegWrite};
  end

  assign memop           = in_Valid & (in_MemRead | in_MemWrite);
  assign misaligned      = (in_ALU_result[1:0] != 2'b00);
  assign issue           = (state == IDLE) & memop & ~misaligned;
  assign misalign_retire = (state == IDLE) & memop & misaligned;
  assign timeout_hit     = (state == ACCESS) & ~mem_ready & (cnt == TO_WIDTH'(TIMEOUT - 1));

  // While an access is in flight the upstream stages are frozen, so the
  // captured copy is the only trustworthy view of the instruction.
  assign cur = (state == ACCESS) ? cap : in_instr;

  // NOTE: every signal written in this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          state_nxt = ACCESS;
          stall     = 1'b1;
        end
      end
      ACCESS: begin
        mem_req = 1'b1;
        // An abort retires the instruction, so upstream must advance with it.
        stall   = ~mem_ready & ~timeout_hit;
        if (mem_ready || timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!RST_N) begin
      mem_req = 1'b0;
      stall   = 1'b0;
    end
  end

  assign mem_we    = mem_req & cur.we;
  assign mem_addr  = mem_req ? {cur.alu[31:2], 2'b00} : 32'h0;
  assign mem_wdata = mem_req ? cur.wdata : 32'h0;

  assign retire     = ((state == IDLE) & in_Valid & ~issue) |
                      ((state == ACCESS) & (mem_ready | timeout_hit));
  assign wr_en      = cur.reg_write & ~misalign_retire & ~timeout_hit;
  assign write_data = ((state == ACCESS) && mem_ready && cur.mem_to_reg) ? mem_rdata : cur.alu;
  assign redirect   = retire & (cur.pc_src | cur.j_to_pc);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
      cap   <= '0;
    end else begin
      state <= state_nxt;
      if (issue) cap <= in_instr;
      if ((state == ACCESS) && !mem_ready && !timeout_hit) cnt <= cnt + TO_WIDTH'(1);
      else                                                  cnt <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_Valid          <= 1'b0;
      out_Write_data     <= '0;
      out_Next_PC        <= '0;
      out_Reg_Write_addr <= '0;
      out_RegWrite       <= 1'b0;
      err_misalign       <= 1'b0;
      err_timeout        <= 1'b0;
      pc_redirect        <= 1'b0;
      pc_target          <= '0;
    end else begin
      out_Valid    <= retire;
      out_RegWrite <= retire & wr_en;
      err_misalign <= misalign_retire;
      err_timeout  <= err_timeout | timeout_hit;
      pc_redirect  <= redirect;
      if (retire) begin
        out_Write_data     <= write_data;
        out_Next_PC        <= cur.next_pc;
        out_Reg_Write_addr <= cur.rd;
      end
      if (redirect) pc_target <= cur.j_to_pc ? cur.jump : cur.branch;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU retire, load/store handshakes,
// misalignment, timeout, redirect and reset during an access.
module tb_mem_access_stage;

  logic        CLK, RST_N;
  logic        in_Valid;
  logic [31:0] in_ALU_result, in_Read_data, in_Next_PC, in_Branch_addr, in_Jump_addr;
  logic [4:0]  in_Reg_Write_addr;
  logic        in_MemWrite, in_MemRead, in_MemToReg, in_PCSrc, in_JToPC, in_RegWrite;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, stall, pc_redirect;
  logic [31:0] pc_target, out_Write_data, out_Next_PC;
  logic        out_Valid;
  logic [4:0]  out_Reg_Write_addr;
  logic        out_RegWrite, err_misalign, err_timeout;

  int n_cmp = 0;
  int n_err = 0;
  int stall_cnt;

  mem_access_stage #(.TIMEOUT(4), .TO_WIDTH(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_Valid(in_Valid), .in_ALU_result(in_ALU_result),
    .in_Read_data(in_Read_data), .in_Next_PC(in_Next_PC), .in_Branch_addr(in_Branch_addr),
    .in_Jump_addr(in_Jump_addr), .in_Reg_Write_addr(in_Reg_Write_addr),
    .in_MemWrite(in_MemWrite), .in_MemRead(in_MemRead), .in_MemToReg(in_MemToReg),
    .in_PCSrc(in_PCSrc), .in_JToPC(in_JToPC), .in_RegWrite(in_RegWrite),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .out_Valid(out_Valid),
    .out_Write_data(out_Write_data), .out_Next_PC(out_Next_PC),
    .out_Reg_Write_addr(out_Reg_Write_addr), .out_RegWrite(out_RegWrite),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    in_Valid = 0; in_ALU_result = 0; in_Read_data = 0; in_Next_PC = 0;
    in_Branch_addr = 0; in_Jump_addr = 0; in_Reg_Write_addr = 0;
    in_MemWrite = 0; in_MemRead = 0; in_MemToReg = 0; in_PCSrc = 0;
    in_JToPC = 0; in_RegWrite = 0;
  endtask

  task automatic drive_lw(input logic [31:0] addr, input logic [4:0] rd);
    clear_inputs();
    in_Valid = 1; in_MemRead = 1; in_MemToReg = 1; in_RegWrite = 1;
    in_ALU_result = addr; in_Reg_Write_addr = rd; in_Next_PC = 32'h20;
  endtask

  initial begin
    RST_N = 0;
    clear_inputs();
    mem_ready = 0;
    mem_rdata = 0;
    #3;
    check("rst_out_valid", out_Valid, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_pc_redirect", pc_redirect, 0);
    drive_lw(32'h100, 5'd1);
    #1;
    check("rst_stall_gated", stall, 0);
    clear_inputs();
    tick();
    tick();
    RST_N = 1;

    // ALU op retires in one cycle without stalling
    in_Valid = 1; in_ALU_result = 32'h1234; in_RegWrite = 1; in_Reg_Write_addr = 5;
    in_Next_PC = 32'h10;
    #1;
    check("alu_stall", stall, 0);
    tick();
    check("alu_valid", out_Valid, 1);
    check("alu_wdata", out_Write_data, 32'h1234);
    check("alu_rd", out_Reg_Write_addr, 5);
    check("alu_regwrite", out_RegWrite, 1);
    check("alu_next_pc", out_Next_PC, 32'h10);
    check("alu_no_redirect", pc_redirect, 0);
    clear_inputs();
    tick();
    check("bubble_valid", out_Valid, 0);
    check("bubble_regwrite", out_RegWrite, 0);

    // Load at 0x100, ready on the 4th ACCESS cycle
    drive_lw(32'h100, 5'd8);
    stall_cnt = 0;
    #1;
    stall_cnt += int'(stall);
    check("lw_idle_no_req", mem_req, 0);
    tick();
    stall_cnt += int'(stall);
    check("lw_req", mem_req, 1);
    check("lw_we", mem_we, 0);
    check("lw_addr", mem_addr, 32'h100);
    check("lw_hold_valid", out_Valid, 0);
    repeat (2) begin
      tick();
      stall_cnt += int'(stall);
    end
    tick();
    mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    #1;
    stall_cnt += int'(stall);
    check("lw_req_last", mem_req, 1);
    tick();
    mem_ready = 0; mem_rdata = 0;
    check("lw_stall_cycles", stall_cnt, 4);
    check("lw_valid", out_Valid, 1);
    check("lw_wdata", out_Write_data, 32'hCAFEF00D);
    check("lw_rd", out_Reg_Write_addr, 8);
    check("lw_regwrite", out_RegWrite, 1);
    check("lw_req_dropped", mem_req, 0);

    // Store at 0x104, ready on the first ACCESS cycle
    clear_inputs();
    in_Valid = 1; in_MemWrite = 1; in_ALU_result = 32'h104; in_Read_data = 32'hA5A5A5A5;
    #1;
    check("sw_stall_idle", stall, 1);
    tick();
    mem_ready = 1;
    #1;
    check("sw_req", mem_req, 1);
    check("sw_we", mem_we, 1);
    check("sw_addr", mem_addr, 32'h104);
    check("sw_wdata", mem_wdata, 32'hA5A5A5A5);
    check("sw_stall_ready", stall, 0);
    tick();
    mem_ready = 0;
    check("sw_valid", out_Valid, 1);
    check("sw_regwrite", out_RegWrite, 0);
    check("sw_we_dropped", mem_we, 0);

    // Misaligned load: no access, error pulse, write suppressed
    drive_lw(32'h102, 5'd9);
    #1;
    check("mis_stall", stall, 0);
    check("mis_no_req", mem_req, 0);
    tick();
    check("mis_valid", out_Valid, 1);
    check("mis_regwrite", out_RegWrite, 0);
    check("mis_err", err_misalign, 1);
    clear_inputs();
    tick();
    check("mis_err_pulse", err_misalign, 0);

    // Timeout: ready never arrives, TIMEOUT=4
    drive_lw(32'h200, 5'd10);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_req_%0d", i), mem_req, 1);
      tick();
    end
    check("to_req_dropped", mem_req, 0);
    check("to_err", err_timeout, 1);
    check("to_valid", out_Valid, 1);
    check("to_regwrite", out_RegWrite, 0);
    clear_inputs();
    tick();
    tick();
    check("to_err_sticky", err_timeout, 1);

    // Jump takes priority over branch
    clear_inputs();
    in_Valid = 1; in_JToPC = 1; in_PCSrc = 1; in_Jump_addr = 32'h400; in_Branch_addr = 32'h200;
    tick();
    check("jmp_redirect", pc_redirect, 1);
    check("jmp_target", pc_target, 32'h400);
    clear_inputs();
    tick();
    check("jmp_pulse", pc_redirect, 0);
    check("jmp_target_hold", pc_target, 32'h400);
    in_Valid = 1; in_PCSrc = 1; in_Branch_addr = 32'h300; in_Jump_addr = 32'h500;
    tick();
    check("br_redirect", pc_redirect, 1);
    check("br_target", pc_target, 32'h300);
    clear_inputs();

    // Reset asserted in the middle of an access
    drive_lw(32'h100, 5'd3);
    tick();
    check("rst_mid_req_before", mem_req, 1);
    #2;
    RST_N = 0;
    #1;
    check("rst_mid_req", mem_req, 0);
    check("rst_mid_stall", stall, 0);
    check("rst_mid_err_timeout", err_timeout, 0);
    clear_inputs();
    tick();
    RST_N = 1;
    tick();
    check("rst_mid_no_retire", out_Valid, 0);
    check("rst_mid_idle", mem_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
